// File: rtl/midi_pkg.sv
// Shared types and default timing for the MIDI serial receive path.
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int MIDI_CYCLES_PER_BIT = 1600;
  localparam int MIDI_DATA_BITS      = 8;

endpackage

// File: rtl/midi_sync_fifo.sv
// First-word-fall-through FIFO; the head entry is always presented on pop_data.
module midi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/midi_uart_rx_fifo.sv
// MIDI/UART receiver: synchroniser, start-glitch rejection, 3-sample majority vote per bit,
// stop-bit check, and a FWFT output FIFO drained over a valid/ready stream.
module midi_uart_rx_fifo
  import midi_pkg::*;
#(
  parameter int CYCLES_PER_BIT = MIDI_CYCLES_PER_BIT,
  parameter int DATA_BITS      = MIDI_DATA_BITS,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          din,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_err,
  output logic                          overrun,
  output logic [2:0]                    state_dbg
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int M  = CYCLES_PER_BIT / 2;

  logic [SYNC_STAGES-1:0] sync;
  logic                   din_s;
  rx_state_t              state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   samp0;
  logic                   samp1;
  logic                   maj;
  logic                   at_decide;
  logic                   at_end;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Stream handshake: m_data is valid whenever m_valid=1; a byte transfers on any
  // cycle where m_valid && m_ready, and m_data holds steady while m_valid && !m_ready.
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign din_s     = sync[SYNC_STAGES-1];
  assign maj       = (samp0 & samp1) | (samp0 & din_s) | (samp1 & din_s);
  assign at_decide = (cnt == CW'(M + 1));
  assign at_end    = (cnt == CW'(CYCLES_PER_BIT - 1));
  assign push      = (state == STOP) && at_decide && maj;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      samp0       <= 1'b1;
      samp1       <= 1'b1;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      if (cnt == CW'(M - 1)) samp0 <= din_s;
      if (cnt == CW'(M))     samp1 <= din_s;
      case (state)
        IDLE: begin
          cnt <= '0;
          // The cycle that first sees the low line is bit cycle 0.
          if (!din_s) begin
            state <= START;
            cnt   <= CW'(1);
          end
        end
        START: begin
          cnt <= cnt + CW'(1);
          if (at_decide && maj) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (at_end) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        DATA: begin
          cnt <= cnt + CW'(1);
          if (at_decide) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
          end
          if (at_end) begin
            cnt <= '0;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        STOP: begin
          cnt <= cnt + CW'(1);
          // Leave mid stop bit so a following start edge is never missed.
          if (at_decide) begin
            cnt <= '0;
            if (maj) begin
              state <= IDLE;
              if (fifo_full && !pop) overrun <= 1'b1;
            end else begin
              state       <= BREAK;
              framing_err <= 1'b1;
            end
          end
        end
        BREAK: begin
          cnt <= '0;
          if (din_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  midi_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(shreg),
    .pop      (pop),
    .pop_data (m_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule
